spike_volley_encoder: RTL and testbench
=======================================

// Module: spike_volley_encoder
// PURPOSE
//  Temporal (race-logic) transmitter that drives spike volleys into a column ahead of lateral_inhibition.
//  Accepts one vector of per-input spike times via valid/ready, then replays it over one gamma cycle.
//  Emits a one-hot-per-input spike_volley on the cycle whose time_val equals that input's spike time.
//  Then emits a rest phase (time_val >= T_PERIOD, no spikes) and pulses gamma_done.
// PARAMETERS
//  NUM_INPUTS  16  number of spike lines (matches neurons_per_layer of the downstream column)
//  T_PERIOD     8  testing period; spike times >= T_PERIOD encode "no spike"
//  GAMMA_LEN   16  total cycles per gamma cycle incl. rest phase; GAMMA_LEN >= T_PERIOD+1
//  TIME_W       5  width of time_val/spike-time fields; 2**TIME_W > GAMMA_LEN-1
// PORTS
//  clk           in   1                  single clock, rising edge
//  rst           in   1                  synchronous, active-high reset
//  in_valid      in   1                  spike_times vector offered
//  in_ready      out  1                  encoder can accept a vector
//  spike_times   in   NUM_INPUTS*TIME_W  field i = bits [i*TIME_W +: TIME_W]
//  time_val      out  TIME_W             current gamma-cycle time, 0..GAMMA_LEN-1
//  spike_volley  out  NUM_INPUTS         bit i high for exactly one cycle at time_val==t_i
//  volley_valid  out  1                  high while time_val/spike_volley are meaningful
//  gamma_done    out  1                  one-cycle pulse after the last time step
// BEHAVIOUR
//  - Reset values: in_ready=0, time_val=0, spike_volley=0, volley_valid=0, gamma_done=0; state=IDLE.
//  - FSM states IDLE, RUN, DONE. All outputs registered.
//  - IDLE: in_ready=1. Transfer happens when in_valid&&in_ready on a rising edge.
//    On transfer, latch all spike times, go to RUN with time_val=0.
//  - RUN: volley_valid=1, in_ready=0. Each cycle time_val increments by 1.
//    spike_volley[i] = (t_i == time_val) && (t_i < T_PERIOD).
//  - RUN covers time_val=0..GAMMA_LEN-1, so each volley is GAMMA_LEN cycles long.
//    In the rest phase (time_val >= T_PERIOD) spike_volley=0 regardless of latched values.
//  - RUN -> DONE after the time_val==GAMMA_LEN-1 cycle.
//    DONE lasts 1 cycle: gamma_done=1, volley_valid=0, spike_volley=0, time_val=0. DONE -> IDLE.
//  - Latency: transfer at edge N -> first volley cycle (time_val=0, volley_valid=1) is the cycle after edge N.
//    Next in_ready=1 is GAMMA_LEN+1 cycles after that.
//  - Several inputs with equal t_i spike together in the same cycle (multi-hot volley is legal).
//  - t_i in [T_PERIOD, 2**TIME_W-1] = no spike. t_i is never wrapped or truncated.
//  - in_valid while busy is ignored; spike_times must not be sampled outside a transfer.
//  - rst asserted mid-RUN: next cycle matches reset values; the latched vector is discarded and
//    no gamma_done pulse is issued.
//  - time_val never exceeds GAMMA_LEN-1; no wrap to 0 inside RUN.
// CONFIGURATION
//  SPIKE_ENCODE_INTENSITY_EN
//   defined: each field is an intensity I, not a time. Spike time is computed at transfer:
//     I==0 -> no spike; 1 <= I <= T_PERIOD-1 -> t = T_PERIOD-1-I; I >= T_PERIOD -> t = 0 (saturate).
//     Brighter inputs spike earlier.
//   undefined: each field is used directly as the spike time t_i.
//  Timing and handshake are identical in both builds.
// TESTING
//  1. rst 3 cycles -> all outputs 0. Release -> in_ready=1 on the next cycle.
//  2. t = {0,3,7,8,...,31}, in_valid 1 cycle -> bit0@tv=0, bit1@tv=3, bit2@tv=7.
//     Fields 8 and 31 never fire. gamma_done 17 cycles after the transfer edge.
//  3. All 16 fields = 5 -> spike_volley=16'hFFFF only at tv=5, 0 at every other step.
//  4. in_valid held high continuously -> transfers spaced exactly GAMMA_LEN+2=18 cycles apart.
//     Second vector ignored while in RUN.
//  5. rst at tv=4 -> next cycle all outputs 0 and in_ready=1 one cycle after rst drops.
//     No gamma_done pulse.
//  6. [SPIKE_ENCODE_INTENSITY_EN] I = {0,1,7,9} -> bit0 never fires, bit1@tv=6, bit2@tv=0, bit3@tv=0.

Source files
------------

// File: rtl/spike_volley_encoder.sv
// Race-logic spike volley transmitter: latches one vector of spike times, replays it over one gamma cycle.
// Optional build macro SPIKE_ENCODE_INTENSITY_EN: fields are intensities converted to spike times at transfer.
module spike_volley_encoder #(
  parameter int NUM_INPUTS = 16,
  parameter int T_PERIOD   = 8,
  parameter int GAMMA_LEN  = 16,
  parameter int TIME_W     = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_INPUTS*TIME_W-1:0] spike_times,
  output logic [TIME_W-1:0]            time_val,
  output logic [NUM_INPUTS-1:0]        spike_volley,
  output logic                         volley_valid,
  output logic                         gamma_done
);

  localparam logic [TIME_W-1:0] T_LIMIT = TIME_W'(T_PERIOD);
  localparam logic [TIME_W-1:0] T_LAST  = TIME_W'(GAMMA_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_reg;
  logic                    take;
  logic [TIME_W-1:0]       next_time;
  logic [NUM_INPUTS-1:0]   first_hits;
  logic [NUM_INPUTS-1:0]   next_hits;

  assign take      = (state_reg == IDLE) && in_ready && in_valid;
  assign next_time = time_val + TIME_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_lane
      logic [TIME_W-1:0] field;
      logic [TIME_W-1:0] enc_time;
      logic [TIME_W-1:0] time_reg;

      assign field = spike_times[gi*TIME_W +: TIME_W];

`ifdef SPIKE_ENCODE_INTENSITY_EN
      localparam logic [TIME_W-1:0] T_EARLIEST = T_LIMIT - TIME_W'(1);
      // Brighter inputs fire earlier; zero intensity maps to the no-spike code.
      always_comb begin
        if (field == '0) begin
          enc_time = T_LIMIT;
        end else if (field < T_LIMIT) begin
          enc_time = T_EARLIEST - field;
        end else begin
          enc_time = '0;
        end
      end
`else
      assign enc_time = field;
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          time_reg <= '1;
        end else if (take) begin
          time_reg <= enc_time;
        end
      end

      // Volley bits are precomputed for the time step the register will present next.
      assign first_hits[gi] = (enc_time == '0);
      assign next_hits[gi]  = (time_reg == next_time) && (time_reg < T_LIMIT);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      in_ready     <= 1'b0;
      time_val     <= '0;
      spike_volley <= '0;
      volley_valid <= 1'b0;
      gamma_done   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          gamma_done <= 1'b0;
          if (take) begin
            state_reg    <= RUN;
            in_ready     <= 1'b0;
            time_val     <= '0;
            volley_valid <= 1'b1;
            spike_volley <= first_hits;
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          if (time_val == T_LAST) begin
            state_reg    <= DONE;
            gamma_done   <= 1'b1;
            volley_valid <= 1'b0;
            spike_volley <= '0;
            time_val     <= '0;
          end else begin
            time_val     <= next_time;
            spike_volley <= next_hits;
          end
        end
        DONE: begin
          state_reg  <= IDLE;
          gamma_done <= 1'b0;
          in_ready   <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_volley_encoder.sv
// Self-checking bench for spike_volley_encoder: cycle model keyed on "cycles since transfer" plus directed literals.
module tb_spike_volley_encoder;
  localparam int N  = 16;
  localparam int TP = 8;
  localparam int GL = 16;
  localparam int TW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*TW-1:0] spike_times = '0;
  logic [TW-1:0]   time_val;
  logic [N-1:0]    spike_volley;
  logic            volley_valid;
  logic            gamma_done;

  spike_volley_encoder #(.NUM_INPUTS(N), .T_PERIOD(TP), .GAMMA_LEN(GL), .TIME_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .spike_times(spike_times), .time_val(time_val), .spike_volley(spike_volley),
    .volley_valid(volley_valid), .gamma_done(gamma_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: p counts cycles since the accepting edge (1..GL volley, GL+1 done, GL+2 ready again).
  bit m_busy  = 1'b0;
  bit m_ready = 1'b0;
  int m_p     = 0;
  int m_t[N];

  function automatic int spike_time_of(input int f);
`ifdef SPIKE_ENCODE_INTENSITY_EN
    if (f == 0) return TP;
    if (f < TP) return TP - 1 - f;
    return 0;
`else
    return f;
`endif
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 1'b0; m_ready = 1'b0; m_p = 0;
    end else if (m_busy) begin
      m_p++;
      if (m_p == GL + 2) begin
        m_busy = 1'b0; m_ready = 1'b1; m_p = 0;
      end
    end else if (m_ready && in_valid) begin
      m_busy = 1'b1; m_p = 1; m_ready = 1'b0;
      for (int i = 0; i < N; i++) m_t[i] = spike_time_of(int'(spike_times[i*TW +: TW]));
    end else begin
      m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      logic          e_vv, e_gd;
      logic [TW-1:0] e_tv;
      logic [N-1:0]  e_sv;
      e_vv = m_busy && (m_p >= 1) && (m_p <= GL);
      e_gd = m_busy && (m_p == GL + 1);
      e_tv = e_vv ? TW'(m_p - 1) : '0;
      e_sv = '0;
      if (e_vv)
        for (int i = 0; i < N; i++) e_sv[i] = (m_t[i] == m_p - 1) && (m_t[i] < TP);
      tests++;
      if (in_ready !== m_ready || volley_valid !== e_vv || gamma_done !== e_gd ||
          time_val !== e_tv || spike_volley !== e_sv) begin
        fails++;
        $display("FAIL model cyc=%0d got rdy=%b vv=%b gd=%b tv=%0d sv=%h want rdy=%b vv=%b gd=%b tv=%0d sv=%h",
                 cyc, in_ready, volley_valid, gamma_done, time_val, spike_volley,
                 m_ready, e_vv, e_gd, e_tv, e_sv);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end else begin
      $display("[TB] ok %s = %0d", name, got);
    end
  endtask

  task automatic send(input logic [N*TW-1:0] v);
    int n;
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("send_ready_wait", int'(in_ready), 1);
    spike_times = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  int ftv[N];
  int fcnt[N];
  int done_k, nz_cycles, full_cycles;

  task automatic capture();
    done_k = -1; nz_cycles = 0; full_cycles = 0;
    for (int i = 0; i < N; i++) begin ftv[i] = -1; fcnt[i] = 0; end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (spike_volley != '0) nz_cycles++;
      if (spike_volley == '1) full_cycles++;
      for (int i = 0; i < N; i++)
        if (spike_volley[i]) begin
          if (fcnt[i] == 0) ftv[i] = int'(time_val);
          fcnt[i]++;
        end
      if (gamma_done) begin
        done_k = k;
        break;
      end
    end
  endtask

  initial begin
    logic [N*TW-1:0] v;
    int   rise[2];
    int   nr, gd_cnt;
    logic prev_vv;

    // 1: reset and release
    repeat (3) @(posedge clk);
    #1 check("reset_outputs_zero", int'({in_ready, volley_valid, gamma_done, time_val, spike_volley}), 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_low_before_edge", int'(in_ready), 0);
    @(posedge clk);
    #1 check("ready_after_release", int'(in_ready), 1);

    // 2: mixed spike times, out-of-window fields never fire
    v = '0;
    for (int i = 0; i < N; i++) v[i*TW +: TW] = TW'(8 + i);
    v[0*TW +: TW] = TW'(0); v[1*TW +: TW] = TW'(3); v[2*TW +: TW] = TW'(7);
    v[3*TW +: TW] = TW'(8); v[15*TW +: TW] = TW'(31);
    send(v);
    capture();
`ifndef SPIKE_ENCODE_INTENSITY_EN
    check("t2_bit0_tv", ftv[0], 0);
    check("t2_bit1_tv", ftv[1], 3);
    check("t2_bit2_tv", ftv[2], 7);
    check("t2_bit1_once", fcnt[1], 1);
    check("t2_bit3_silent", fcnt[3], 0);
    check("t2_bit15_silent", fcnt[15], 0);
`endif
    check("t2_done_offset", done_k, 17);

    // 3: all fields equal -> one full multi-hot volley
    v = '0;
    for (int i = 0; i < N; i++) v[i*TW +: TW] = TW'(5);
    send(v);
    capture();
`ifndef SPIKE_ENCODE_INTENSITY_EN
    check("t3_full_cycles", full_cycles, 1);
    check("t3_nonzero_cycles", nz_cycles, 1);
    check("t3_fire_tv", ftv[9], 5);
`endif

    // 4: in_valid held high; bus changes while busy; transfers 18 cycles apart
    v = '0;
    for (int i = 0; i < N; i++) v[i*TW +: TW] = TW'(i % 9);
    while (!in_ready) @(negedge clk);
    spike_times = v;
    in_valid = 1'b1;
    nr = 0; prev_vv = 1'b0; rise[0] = 0; rise[1] = 0;
    for (int k = 0; k < 60 && nr < 2; k++) begin
      @(negedge clk);
      if (volley_valid && !prev_vv) begin
        rise[nr] = cyc;
        nr++;
        for (int i = 0; i < N; i++) v[i*TW +: TW] = TW'((i + 2) % 11);
        spike_times = v;
      end
      prev_vv = volley_valid;
    end
    in_valid = 1'b0;
    check("t4_transfer_count", nr, 2);
    check("t4_spacing", rise[1] - rise[0], GL + 2);
    capture();

    // 5: reset mid-run at tv=4 discards the volley and suppresses gamma_done
    v = '0;
    for (int i = 0; i < N; i++) v[i*TW +: TW] = TW'(i % 8);
    send(v);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (volley_valid && time_val == TW'(4)) break;
    end
    check("t5_reached_tv4", int'(time_val), 4);
    rst = 1'b1;
    @(posedge clk);
    #1 check("t5_reset_outputs_zero", int'({in_ready, volley_valid, gamma_done, time_val, spike_volley}), 0);
    rst = 1'b0;
    @(posedge clk);
    #1 check("t5_ready_after_drop", int'(in_ready), 1);
    gd_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (gamma_done) gd_cnt++;
    end
    check("t5_no_gamma_done", gd_cnt, 0);

`ifdef SPIKE_ENCODE_INTENSITY_EN
    // 6: intensity mapping
    v = '0;
    v[0*TW +: TW] = TW'(0); v[1*TW +: TW] = TW'(1);
    v[2*TW +: TW] = TW'(7); v[3*TW +: TW] = TW'(9);
    send(v);
    capture();
    check("t6_bit0_silent", fcnt[0], 0);
    check("t6_bit1_tv", ftv[1], 6);
    check("t6_bit2_tv", ftv[2], 0);
    check("t6_bit3_tv", ftv[3], 0);
`endif

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
